// File: rtl/contador_pkg.sv
// ---------------------------------------------------------------------------
// contador_pkg
// Shared definitions for the counter/timer blocks of the game datapath.
//   cr_state_t : control states of the countdown timer (cuenta_regresiva)
//   CNT_W      : default count width, matching the 4-bit display path
// ---------------------------------------------------------------------------
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } cr_state_t;

    localparam int CNT_W = 4;

endpackage : contador_pkg

// File: rtl/divisor_tick.sv
// ---------------------------------------------------------------------------
// divisor_tick
// Clock prescaler: counts 0..PRESCALE-1 while run_i is high and produces a
// one-cycle tick in the cycle where the terminal count is reached, wrapping
// back to 0 on that edge. When run_i is low the count holds its value.
// clr_i forces the count to 0 and takes priority over run_i.
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_n_i  in   asynchronous active-low reset
//   run_i    in   advance the prescaler this cycle
//   clr_i    in   synchronous clear to 0 (priority over run_i)
//   tick_o   out  high during the cycle whose edge completes a period
// ---------------------------------------------------------------------------
module divisor_tick
    import contador_pkg::*;
#(
    parameter int PRESCALE = 10
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic run_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int              PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (run_i) begin
            if (w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + PW'(1);
            end
        end
    end

    // Combinational so the consumer can act on the same edge that wraps.
    assign tick_o = run_i & ~clr_i & w_at_last;

endmodule : divisor_tick

// File: rtl/cuenta_regresiva.sv
// ---------------------------------------------------------------------------
// cuenta_regresiva
// Loadable countdown timer. Counts from a preset down to zero, one step every
// PRESCALE clock cycles, with start / pause / resume control. A one-cycle
// done_o pulse marks the edge on which the count reaches zero.
// Input priority in any cycle: load_i > start_i > pause_i.
//
// Ports
//   clk_i       in   clock, rising edge
//   rst_n_i     in   asynchronous active-low reset
//   load_i      in   load load_val_i (honoured in IDLE, PAUSE, DONE)
//   load_val_i  in   preset value
//   start_i     in   start from IDLE / resume from PAUSE
//   pause_i     in   pause while running
//   data_o      out  current count (registered)
//   busy_o      out  high in RUN or PAUSE (registered)
//   done_o      out  one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
module cuenta_regresiva
    import contador_pkg::*;
#(
    parameter int WIDTH    = CNT_W,
    parameter int PRESCALE = 10
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             pause_i,
    output logic [WIDTH-1:0] data_o,
    output logic             busy_o,
    output logic             done_o
);

    cr_state_t        r_state;
    cr_state_t        w_state_next;

    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_data_next;
    logic             w_busy_next;
    logic             w_done_next;

    logic             w_tick;
    logic             w_run;
    logic             w_clr;
    logic             w_is_zero;
    logic             w_is_one;

    assign w_is_zero = (r_data == '0);
    assign w_is_one  = (r_data == WIDTH'(1));

    // The prescaler only advances in RUN; the cycle on which pause_i is
    // sampled is still a RUN cycle, so it counts. Outside RUN/PAUSE it is
    // held at 0 so a fresh start always begins a full period. A load in
    // PAUSE abandons the partial period.
    assign w_run = (r_state == RUN);
    assign w_clr = (r_state == IDLE) || (r_state == DONE) ||
                   ((r_state == PAUSE) && load_i);

    divisor_tick #(
        .PRESCALE (PRESCALE)
    ) u_divisor_tick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .run_i   (w_run),
        .clr_i   (w_clr),
        .tick_o  (w_tick)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (load_i) begin
                    w_state_next = IDLE;
                end else if (start_i) begin
                    w_state_next = w_is_zero ? DONE : RUN;
                end
            end
            RUN: begin
                // Reaching zero beats a simultaneous pause request.
                if (w_tick && w_is_one) begin
                    w_state_next = DONE;
                end else if (pause_i) begin
                    w_state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (load_i) begin
                    w_state_next = IDLE;
                end else if (start_i) begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                if (load_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic (values the output registers take on the next edge)
    always_comb begin
        w_data_next = r_data;
        w_done_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_i) begin
                    w_data_next = load_val_i;
                end else if (start_i && w_is_zero) begin
                    w_done_next = 1'b1;
                end
            end
            RUN: begin
                if (w_tick && !w_is_zero) begin
                    w_data_next = r_data - WIDTH'(1);
                    w_done_next = w_is_one;
                end
            end
            PAUSE: begin
                if (load_i) begin
                    w_data_next = load_val_i;
                end
            end
            DONE: begin
                w_data_next = load_i ? load_val_i : '0;
            end
            default: begin
                w_data_next = '0;
            end
        endcase
        w_busy_next = (w_state_next == RUN) || (w_state_next == PAUSE);
    end

    // Output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_data <= w_data_next;
            r_busy <= w_busy_next;
            r_done <= w_done_next;
        end
    end

    assign data_o = r_data;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule : cuenta_regresiva

// File: tb/tb_cuenta_regresiva.sv
module tb_cuenta_regresiva;

    localparam int P = 4;
    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] val   = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic [W-1:0] data;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 running, 2 paused, 3 finished.
    // While running, the count is the preset minus whole periods elapsed.
    int m_mode    = 0;
    int m_cnt     = 0;
    int m_base    = 0;
    int m_elapsed = 0;
    bit m_done    = 1'b0;

    cuenta_regresiva #(
        .WIDTH    (W),
        .PRESCALE (P)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .load_i     (load),
        .load_val_i (val),
        .start_i    (start),
        .pause_i    (pause),
        .data_o     (data),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_cnt     = 0;
        m_base    = 0;
        m_elapsed = 0;
        m_done    = 1'b0;
    endtask

    task automatic model_step(input bit ld, input int v, input bit st, input bit ps);
        m_done = 1'b0;
        case (m_mode)
            0: begin
                if (ld) m_cnt = v;
                else if (st) begin
                    if (m_cnt == 0) begin
                        m_mode = 3;
                        m_done = 1'b1;
                    end else begin
                        m_mode    = 1;
                        m_base    = m_cnt;
                        m_elapsed = 0;
                    end
                end
            end
            1: begin
                m_elapsed++;
                m_cnt = m_base - m_elapsed / P;
                if (m_cnt == 0) begin
                    m_mode = 3;
                    m_done = 1'b1;
                end else if (ps) begin
                    m_mode = 2;
                end
            end
            2: begin
                if (ld) begin
                    m_cnt  = v;
                    m_mode = 0;
                end else if (st) begin
                    m_mode = 1;
                end
            end
            default: begin
                if (ld) begin
                    m_cnt  = v;
                    m_mode = 0;
                end
            end
        endcase
    endtask

    // One clock transaction: drive, clock, advance model, compare outputs.
    task automatic step(input bit ld, input int v, input bit st, input bit ps);
        load  = ld;
        val   = v[W-1:0];
        start = st;
        pause = ps;
        @(posedge clk);
        model_step(ld, v, st, ps);
        #1;
        $display("t=%0t ld=%0b v=%0d st=%0b ps=%0b -> data=%0d busy=%0b done=%0b",
                 $time, ld, v, st, ps, data, busy, done);
        chk("data", data, m_cnt);
        chk("busy", busy, (m_mode == 1 || m_mode == 2));
        chk("done", done, m_done);
    endtask

    initial begin
        int done_k;
        int dec_k;

        // Reset state
        model_reset();
        #2;
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic countdown: load 3, start at N -> 2,1,0 at N+4,N+8,N+12
        step(1, 3, 0, 0);
        step(0, 0, 1, 0);
        done_k = -1;
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 0);
            if (k == 4) chk("cd_at4", data, 2);
            if (k == 8) chk("cd_at8", data, 1);
            if (k == 11) chk("cd_busy11", busy, 1);
            if (done === 1'b1 && done_k < 0) done_k = k;
        end
        chk("cd_done_edge", done_k, 12);

        // Pause/resume: start N, pause N+2, resume N+7
        step(1, 2, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        done_k = -1;
        dec_k  = -1;
        for (int k = 8; k <= 15; k++) begin
            step(0, 0, 0, 0);
            if (data == 1 && dec_k < 0) dec_k = k;
            if (done === 1'b1 && done_k < 0) done_k = k;
        end
        chk("pr_first_dec", dec_k, 9);
        chk("pr_done_edge", done_k, 13);

        // Pause on the final tick: completion wins
        step(1, 1, 0, 0);
        step(0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("sp_done", done, 1);
        chk("sp_busy", busy, 0);
        step(0, 0, 0, 0);
        chk("sp_pulse_once", done, 0);

        // Zero preset
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        step(0, 0, 1, 0);
        chk("z_no_repulse", done, 0);

        // Priority: load beats start; load ignored in RUN
        step(1, 7, 1, 0);
        chk("pri_data", data, 7);
        chk("pri_idle", busy, 0);
        step(0, 0, 1, 0);
        step(1, 2, 0, 0);
        chk("pri_run_load", data, 7);
        repeat (6) step(0, 0, 0, 0);
        chk("pri_count", data, 6);

        // Reset mid-run
        step(1, 5, 0, 0);
        step(0, 0, 1, 0);
        repeat (6) step(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("amr_data", data, 0);
        chk("amr_busy", busy, 0);
        chk("amr_done", done, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) step(0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 11) == 0, int'($urandom_range(0, 6)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cuenta_regresiva
